fp2_sub_arbiter: RTL and testbench

FP2_SUB_ARBITER -- requirements
Module: fp2_sub_arbiter

---
 rtl/fp2_sub_arbiter.sv | 105 ++++++++++
 tb/tb_fp2_sub_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fp2_sub_arbiter.sv
// fp2_sub_arbiter: shares one pipelined fp2_sub unit among NUM_REQ requesters with per-requester credits.
// Define FP2_SUB_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module fp2_sub_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 3,
    parameter int W = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a1,
    input  logic [NUM_REQ*W-1:0] req_b1,
    input  logic [NUM_REQ*W-1:0] req_a2,
    input  logic [NUM_REQ*W-1:0] req_b2,
    output logic [W-1:0]         sub_A1,
    output logic [W-1:0]         sub_B1,
    output logic [W-1:0]         sub_A2,
    output logic [W-1:0]         sub_B2,
    input  logic [W-1:0]         sub_D1,
    input  logic [W-1:0]         sub_D2,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_d1,
    output logic [W-1:0]         rsp_d2
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);
    logic [NUM_REQ-1:0] elig, rsp_vec;
    logic [NUM_REQ-1:0][CW-1:0] cnt;
    logic [LATENCY:0] tv;
    logic [LATENCY:0][IW-1:0] tid;
    logic [IW-1:0] gnt, start;
    logic gnt_v;
    logic [W-1:0] a1_q, b1_q, a2_q, b2_q;
`ifdef FP2_SUB_ARB_RR_EN
    logic [IW-1:0] ptr;
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (gnt_v) ptr <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
    end
    assign start = ptr;
`else
    assign start = '0;
`endif
    // A response in flight frees its credit in the same cycle, so a full requester may reissue at once.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) req_ready[i] = !rst && (cnt[i] < MAXC || rsp_vec[i]);
    end
    assign elig = req_valid & req_ready;
    always_comb begin
        int j;
        j = 0;
        gnt_v = 1'b0;
        gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(start) + k;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (!gnt_v && elig[j]) begin
                gnt_v = 1'b1;
                gnt = IW'(j);
            end
        end
    end
    // Tag stage 0 lines up with the operand register; the remaining LATENCY stages track the fp2_sub pipeline.
    assign rsp_vec = tv[LATENCY] ? NUM_REQ'(1) << tid[LATENCY] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tv <= '0;
            tid <= '0;
            a1_q <= '0;
            b1_q <= '0;
            a2_q <= '0;
            b2_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                cnt[i] <= (gnt_v && gnt == IW'(i) && !rsp_vec[i]) ? cnt[i] + CW'(1) :
                          (!(gnt_v && gnt == IW'(i)) && rsp_vec[i]) ? cnt[i] - CW'(1) : cnt[i];
            tv <= {tv[LATENCY-1:0], gnt_v};
            tid <= {tid[LATENCY-1:0], gnt};
            if (gnt_v) begin
                a1_q <= req_a1[gnt*W +: W];
                b1_q <= req_b1[gnt*W +: W];
                a2_q <= req_a2[gnt*W +: W];
                b2_q <= req_b2[gnt*W +: W];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst)
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (!(rsp_vec[i] && cnt[i] == '0));
                assert (cnt[i] <= MAXC);
            end
    end
    assign sub_A1 = rst ? '0 : a1_q;
    assign sub_B1 = rst ? '0 : b1_q;
    assign sub_A2 = rst ? '0 : a2_q;
    assign sub_B2 = rst ? '0 : b2_q;
    assign rsp_valid = rst ? '0 : rsp_vec;
    assign rsp_d1 = rst ? '0 : sub_D1;
    assign rsp_d2 = rst ? '0 : sub_D2;
endmodule

// File: tb/tb_fp2_sub_arbiter.sv
// tb_fp2_sub_arbiter: randomized scoreboard bench with an fp2_sub model behind the arbiter.
module tb_fp2_sub_arbiter;
    localparam int N = 2;
    localparam int LAT = 3;
    localparam int MO = 3;
    localparam int W = 255;
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    typedef struct {
        int id;
        int due;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [N*W-1:0] req_a1 = '0, req_b1 = '0, req_a2 = '0, req_b2 = '0;
    logic [W-1:0] sub_A1, sub_B1, sub_A2, sub_B2, sub_D1, sub_D2, rsp_d1, rsp_d2;

    exp_t sb[$];
    logic [N-1:0] exp_ready = '0;
    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int rr = 0;

    fp2_sub_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .MAX_OUT(MO), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a1(req_a1), .req_b1(req_b1), .req_a2(req_a2), .req_b2(req_b2),
        .sub_A1(sub_A1), .sub_B1(sub_B1), .sub_A2(sub_A2), .sub_B2(sub_B2),
        .sub_D1(sub_D1), .sub_D2(sub_D2),
        .rsp_valid(rsp_valid), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [255:0] x;
        x = {1'b0, a} + ((a >= b) ? 256'd0 : P) - {1'b0, b};
        return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return {1'b0, r[253:0]};
    endfunction

    // Shared fp2_sub unit: LAT register stages after the arbiter's operand register.
    logic [W-1:0] p1 [LAT];
    logic [W-1:0] p2 [LAT];
    always @(posedge clk) begin
        p1[0] <= fsub(sub_A1, sub_B1);
        p2[0] <= fsub(sub_A2, sub_B2);
        for (int k = 1; k < LAT; k++) begin
            p1[k] <= p1[k-1];
            p2[k] <= p2[k-1];
        end
    end
    assign sub_D1 = p1[LAT-1];
    assign sub_D2 = p2[LAT-1];

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    // One cycle of stimulus; the model decides readiness and the winner from the queue of in-flight ops.
    task automatic step(input logic [N-1:0] v, input logic r, input bit dir = 0);
        int n, g, idx;
        @(posedge clk);
        #1;
        rst = r;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a1[i*W +: W] = dir ? W'(9) : rnd();
            req_b1[i*W +: W] = dir ? W'(4) : rnd();
            req_a2[i*W +: W] = dir ? W'(7) : rnd();
            req_b2[i*W +: W] = dir ? W'(2) : rnd();
        end
        if (r) begin
            sb.delete();
            exp_ready = '0;
            rr = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                n = 0;
                foreach (sb[k]) if (sb[k].id == i && sb[k].due > cyc) n++;
                exp_ready[i] = n < MO;
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
`ifdef FP2_SUB_ARB_RR_EN
                idx = (rr + k) % N;
`else
                idx = k;
`endif
                if (g < 0 && v[idx] && exp_ready[idx]) g = idx;
            end
            if (g >= 0) begin
                sb.push_back('{g, cyc + LAT + 1,
                               fsub(req_a1[g*W +: W], req_b1[g*W +: W]),
                               fsub(req_a2[g*W +: W], req_b2[g*W +: W])});
                rr = (g + 1) % N;
            end
        end
    endtask

    always @(negedge clk) begin
        chk("req_ready", 512'(req_ready), 512'(exp_ready));
        if (rst) begin
            chk("rst_rsp", 512'({rsp_valid, rsp_d1}), '0);
            chk("rst_d2", 512'(rsp_d2), '0);
            chk("rst_sub1", 512'({sub_A1, sub_B1}), '0);
            chk("rst_sub2", 512'({sub_A2, sub_B2}), '0);
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("rsp_valid", 512'(rsp_valid), 512'(N'(1) << sb[0].id));
            chk("rsp_d1", 512'(rsp_d1), 512'(sb[0].d1));
            chk("rsp_d2", 512'(rsp_d2), 512'(sb[0].d2));
            void'(sb.pop_front());
        end else begin
            chk("rsp_idle", 512'(rsp_valid), '0);
        end
    end

    initial begin
        repeat (3) step('0, 1);
        step(2'b10, 0, 1);
        repeat (6) step('0, 0);
        repeat (4) step(2'b11, 0);
        repeat (8) step('0, 0);
        repeat (8) step(2'b01, 0);
        repeat (6) step('0, 0);
        step(2'b11, 0);
        step(2'b11, 0);
        step('0, 1);
        repeat (6) step('0, 0);
        repeat (10) step(2'b11, 0);
        repeat (6) step('0, 0);
        repeat (300) step(N'($urandom), 0);
        step('0, 1);
        repeat (20) step(N'($urandom), 0);
        repeat (LAT + 3) step('0, 0);
        @(posedge clk);
        #1;
        chk("drain_empty", 512'(sb.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
